if_stage_param: RTL and testbench
=================================

Name: if_stage_param

Overview:
Parametrised instruction-fetch stage. It owns its program counter internally, drives an asynchronous-read instruction ROM, and registers instruction and PC into the IF/ID pipeline boundary. Compared with the fixed 10/32-bit fetch stage, it adds stall, same-cycle branch/jump redirect, a HALT detection state machine, a valid qualifier and a fetched-instruction counter. It sits between the ROM and the decode stage; the hazard unit drives stall and the execute/branch logic drives redirect.

Parameters:
PC_W, 10, PC / ROM address width; ROM depth is 2^PC_W words.
INSTR_W, 32, instruction width.
PC_STEP, 1, PC increment per fetch (word-addressed ROM).
RESET_PC, 0, PC value after reset.
HALT_EN, 1, 1 enables HALT detection; 0 makes HALTED unreachable.
HALT_INSTR, 32'hFFFF_FFFF, encoding that halts fetch; width INSTR_W.
CNT_W, 16, fetch counter width.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high; dominates all other inputs.
stall  in  1  hold all fetch state this cycle.
redirect_valid  in  1  take redirect_pc this cycle.
redirect_pc  in  PC_W  branch/jump target.
rom_addr  out  PC_W  combinational ROM address.
rom_data  in  INSTR_W  combinational ROM read data for rom_addr.
instr  out  INSTR_W  registered instruction to decode.
instr_pc  out  PC_W  address of instr.
pc_next  out  PC_W  instr_pc + PC_STEP, registered.
instr_valid  out  1  instr is a real fetched instruction.
halted  out  1  state == HALTED.
fetch_count  out  CNT_W  number of cycles with instr_valid loaded as 1.

Behaviour:
- Internal pc_q. rom_addr = redirect_valid ? redirect_pc : pc_q (combinational). fa denotes rom_addr; all PC arithmetic is modulo 2^PC_W, so pc_q = 2^PC_W - PC_STEP wraps to 0.
- States: RUN, HALTED. Reset values: state=RUN, pc_q=RESET_PC, instr=0, instr_pc=0, pc_next=0, instr_valid=0, fetch_count=0.
- Per-posedge priority is reset > redirect_valid > stall > state action.
- redirect_valid=1, from any state and even with stall=1:
  - instr<=rom_data; instr_pc<=fa; pc_next<=fa+PC_STEP.
  - instr_valid<=1; pc_q<=fa+PC_STEP; fetch_count++.
  - Next state is RUN, or HALTED if the halt test below hits. Redirect is zero-bubble.
- stall=1 and no redirect: all registers hold, including instr_valid and fetch_count.
- RUN, no stall, no redirect: same loads as redirect, with fa=pc_q.
- Halt test, applied on any load in RUN or on redirect: if HALT_EN and rom_data==HALT_INSTR:
  - The HALT instruction itself is delivered with instr_valid<=1.
  - pc_q<=fa, i.e. it does not advance.
  - state<=HALTED.
- HALTED, no stall, no redirect: instr<=0, instr_valid<=0, pc_q/instr_pc/pc_next hold, fetch_count holds. Exit only by redirect or reset.
- fetch_count wraps modulo 2^CNT_W.
- Latency: one cycle from rom_addr presentation to instr/instr_valid.
- Reset asserted mid-stall, mid-redirect or in HALTED returns all outputs to reset values on that edge. The first fetch after deassertion reads RESET_PC.
- halted is a combinational decode of state.

Test Plan:
- Reset, then 4 free-run cycles with ROM[i]=i+0x100 -> instr_pc 0,1,2,3; instr 0x100..0x103; pc_next 1..4; instr_valid=1 from the 1st edge after reset; fetch_count=4.
- Stall 3 cycles at pc_q=5 -> instr/instr_pc/fetch_count frozen; rom_addr=5 throughout; after release instr_pc=5.
- redirect_valid with redirect_pc=0x200 and stall=1 simultaneously -> next instr=ROM[0x200], instr_pc=0x200, pc_next=0x201; then 0x201 is fetched.
- ROM[7]=HALT_INSTR -> instr_pc=7 delivered with valid=1, halted=1; subsequent cycles instr=0, valid=0, rom_addr=7, fetch_count frozen; redirect to 0 resumes RUN.
- PC_W=4, pc_q=15 -> next instr_pc=15, then 0; pc_next shows 0 at the wrap.
- Reset asserted while HALTED with fetch_count=9 -> all outputs 0 and state RUN on the same edge; next fetch is at RESET_PC.

Source files
------------

// File: rtl/if_stage_param.sv
// ---------------------------------------------------------------------------
// if_stage_param
// Parametrised instruction-fetch stage with an internal PC. It drives a
// combinational ROM address, registers the returned instruction and its PC
// into the IF/ID boundary, and supports stall, zero-bubble redirect, HALT
// detection, an instruction-valid qualifier and a fetched-instruction counter.
//
// Ports:
//   clk            in   clock, all state updates on posedge
//   reset          in   synchronous active-high reset, dominates everything
//   stall          in   hold all fetch state this cycle
//   redirect_valid in   take redirect_pc this cycle (overrides stall)
//   redirect_pc    in   branch/jump target
//   rom_addr       out  combinational ROM address
//   rom_data       in   combinational ROM read data for rom_addr
//   instr          out  registered instruction to decode
//   instr_pc       out  address of instr
//   pc_next        out  instr_pc + PC_STEP, registered
//   instr_valid    out  instr is a real fetched instruction
//   halted         out  fetch state machine is in HALTED
//   fetch_count    out  number of loads with instr_valid set
// ---------------------------------------------------------------------------
module if_stage_param #(
  parameter int unsigned          PC_W       = 10,
  parameter int unsigned          INSTR_W    = 32,
  parameter int unsigned          PC_STEP    = 1,
  parameter int unsigned          RESET_PC   = 0,
  parameter int unsigned          HALT_EN    = 1,
  parameter logic [INSTR_W-1:0]   HALT_INSTR = {INSTR_W{1'b1}},
  parameter int unsigned          CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic [PC_W-1:0]    pc_next,
  output logic               instr_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  localparam logic [PC_W-1:0] STEP   = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  logic [0:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic [PC_W-1:0]    pc_next_q, pc_next_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PC_W-1:0]    fa;
  logic               load;
  logic               halt_hit;

  // Redirect target goes straight to the ROM so the branch costs no bubble.
  assign fa       = redirect_valid ? redirect_pc : pc_q;
  assign rom_addr = fa;

  // Redirect wins over stall; a plain fetch only happens in RUN.
  assign load     = redirect_valid || (!stall && (state_q == ST_RUN));
  assign halt_hit = (HALT_EN != 0) && (rom_data == HALT_INSTR);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pc_next_d  = pc_next_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    if (load) begin
      instr_d    = rom_data;
      instr_pc_d = fa;
      pc_next_d  = fa + STEP;
      valid_d    = 1'b1;
      cnt_d      = cnt_q + CNT_W'(1);
      // The HALT word is delivered, but the PC parks on it.
      pc_d       = halt_hit ? fa : (fa + STEP);
      state_d    = halt_hit ? ST_HALTED : ST_RUN;
    end else if (!stall && (state_q == ST_HALTED)) begin
      instr_d = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= PC_RST;
      instr_q    <= '0;
      instr_pc_q <= '0;
      pc_next_q  <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      pc_next_q  <= pc_next_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_next     = pc_next_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == ST_HALTED);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage_param.sv
module tb_if_stage_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        rv;
  logic [9:0]  rpc;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] instr;
  logic [9:0]  instr_pc;
  logic [9:0]  pc_next;
  logic        instr_valid;
  logic        halted;
  logic [15:0] fetch_count;

  // narrow instance: PC_W=4, HALT detection disabled
  logic        rv2;
  logic [3:0]  rpc2;
  logic [3:0]  rom_addr2;
  logic [31:0] rom_data2;
  logic [31:0] instr2;
  logic [3:0]  instr_pc2;
  logic [3:0]  pc_next2;
  logic        instr_valid2;
  logic        halted2;
  logic [15:0] fetch_count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rom_data  = (rom_addr == 10'd7) ? 32'hFFFF_FFFF : (32'h100 + 32'(rom_addr));
  assign rom_data2 = (rom_addr2 == 4'd3) ? 32'hFFFF_FFFF : (32'hA000 + 32'(rom_addr2));

  if_stage_param dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(rv), .redirect_pc(rpc),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .pc_next(pc_next),
    .instr_valid(instr_valid), .halted(halted), .fetch_count(fetch_count)
  );

  if_stage_param #(.PC_W(4), .HALT_EN(0)) dut2 (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(rv2), .redirect_pc(rpc2),
    .rom_addr(rom_addr2), .rom_data(rom_data2),
    .instr(instr2), .instr_pc(instr_pc2), .pc_next(pc_next2),
    .instr_valid(instr_valid2), .halted(halted2), .fetch_count(fetch_count2)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [9:0]  rpc;
    logic [9:0]  fa;
    logic [31:0] instr;
    logic [9:0]  ipc;
    logic [9:0]  pcn;
    logic        v;
    logic        h;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic v_rv, input logic [9:0] v_rpc,
                     input logic [9:0] v_fa, input logic [31:0] v_instr, input logic [9:0] v_ipc,
                     input logic [9:0] v_pcn, input logic v_v, input logic v_h, input logic [15:0] v_cnt);
    vec_t t;
    t.rst = r; t.stall = s; t.rv = v_rv; t.rpc = v_rpc; t.fa = v_fa;
    t.instr = v_instr; t.ipc = v_ipc; t.pcn = v_pcn; t.v = v_v; t.h = v_h; t.cnt = v_cnt;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic chk2(input string name, input int idx, input logic [31:0] e_instr, input logic [3:0] e_ipc,
                      input logic [3:0] e_pcn, input logic e_v, input logic [15:0] e_cnt);
    chk({name, "_instr"}, idx, 64'(instr2), 64'(e_instr));
    chk({name, "_pc"},    idx, 64'(instr_pc2), 64'(e_ipc));
    chk({name, "_pcnext"}, idx, 64'(pc_next2), 64'(e_pcn));
    chk({name, "_valid"}, idx, 64'(instr_valid2), 64'(e_v));
    chk({name, "_halted"}, idx, 64'(halted2), 64'(0));
    chk({name, "_count"}, idx, 64'(fetch_count2), 64'(e_cnt));
  endtask

  initial begin
    //   rst st rv rpc     fa      instr          ipc     pcn     v  h  cnt
    add(0, 0, 0, 10'h000, 10'h000, 32'h100,       10'h000, 10'h001, 1, 0, 1);
    add(0, 0, 0, 10'h000, 10'h001, 32'h101,       10'h001, 10'h002, 1, 0, 2);
    add(0, 0, 0, 10'h000, 10'h002, 32'h102,       10'h002, 10'h003, 1, 0, 3);
    add(0, 0, 0, 10'h000, 10'h003, 32'h103,       10'h003, 10'h004, 1, 0, 4);
    add(0, 0, 0, 10'h000, 10'h004, 32'h104,       10'h004, 10'h005, 1, 0, 5);
    add(0, 1, 0, 10'h000, 10'h005, 32'h104,       10'h004, 10'h005, 1, 0, 5);
    add(0, 1, 0, 10'h000, 10'h005, 32'h104,       10'h004, 10'h005, 1, 0, 5);
    add(0, 1, 0, 10'h000, 10'h005, 32'h104,       10'h004, 10'h005, 1, 0, 5);
    add(0, 0, 0, 10'h000, 10'h005, 32'h105,       10'h005, 10'h006, 1, 0, 6);
    add(0, 1, 1, 10'h200, 10'h200, 32'h300,       10'h200, 10'h201, 1, 0, 7);
    add(0, 0, 0, 10'h000, 10'h201, 32'h301,       10'h201, 10'h202, 1, 0, 8);
    add(0, 0, 1, 10'h007, 10'h007, 32'hFFFF_FFFF, 10'h007, 10'h008, 1, 1, 9);
    add(0, 0, 0, 10'h000, 10'h007, 32'h0,         10'h007, 10'h008, 0, 1, 9);
    add(0, 1, 0, 10'h000, 10'h007, 32'h0,         10'h007, 10'h008, 0, 1, 9);
    add(0, 0, 0, 10'h000, 10'h007, 32'h0,         10'h007, 10'h008, 0, 1, 9);
    add(1, 0, 1, 10'h050, 10'h050, 32'h0,         10'h000, 10'h000, 0, 0, 0);
    add(0, 0, 0, 10'h000, 10'h000, 32'h100,       10'h000, 10'h001, 1, 0, 1);
    add(0, 0, 1, 10'h007, 10'h007, 32'hFFFF_FFFF, 10'h007, 10'h008, 1, 1, 2);
    add(0, 0, 1, 10'h000, 10'h000, 32'h100,       10'h000, 10'h001, 1, 0, 3);
    add(0, 0, 0, 10'h000, 10'h001, 32'h101,       10'h001, 10'h002, 1, 0, 4);
    add(0, 1, 0, 10'h000, 10'h002, 32'h0,         10'h000, 10'h000, 0, 0, 0);
    vecs[$].rst = 1'b1;
    add(0, 0, 0, 10'h000, 10'h000, 32'h100,       10'h000, 10'h001, 1, 0, 1);
    add(0, 0, 1, 10'h3FF, 10'h3FF, 32'h4FF,       10'h3FF, 10'h000, 1, 0, 2);
    add(0, 0, 0, 10'h000, 10'h000, 32'h100,       10'h000, 10'h001, 1, 0, 3);

    reset = 1'b1; stall = 1'b0; rv = 1'b0; rpc = '0; rv2 = 1'b0; rpc2 = '0;
    @(posedge clk); #1;
    chk("rst_instr", -1, 64'(instr), 64'h0);
    chk("rst_pc", -1, 64'(instr_pc), 64'h0);
    chk("rst_pcnext", -1, 64'(pc_next), 64'h0);
    chk("rst_valid", -1, 64'(instr_valid), 64'h0);
    chk("rst_halted", -1, 64'(halted), 64'h0);
    chk("rst_count", -1, 64'(fetch_count), 64'h0);
    chk("rst_romaddr", -1, 64'(rom_addr), 64'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; stall = vecs[i].stall; rv = vecs[i].rv; rpc = vecs[i].rpc;
      #1;
      chk("rom_addr", i, 64'(rom_addr), 64'(vecs[i].fa));
      @(posedge clk); #1;
      chk("instr", i, 64'(instr), 64'(vecs[i].instr));
      chk("instr_pc", i, 64'(instr_pc), 64'(vecs[i].ipc));
      chk("pc_next", i, 64'(pc_next), 64'(vecs[i].pcn));
      chk("valid", i, 64'(instr_valid), 64'(vecs[i].v));
      chk("halted", i, 64'(halted), 64'(vecs[i].h));
      chk("count", i, 64'(fetch_count), 64'(vecs[i].cnt));
    end

    // Narrow PC wrap and disabled HALT detection on the PC_W=4 instance.
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; rv = 1'b0; rv2 = 1'b0;
    @(negedge clk);
    reset = 1'b0; rv2 = 1'b1; rpc2 = 4'd14;
    @(posedge clk); #1;
    chk2("w14", 0, 32'hA00E, 4'd14, 4'd15, 1'b1, 16'd1);
    @(negedge clk);
    rv2 = 1'b0;
    #1;
    chk("w_romaddr15", 1, 64'(rom_addr2), 64'd15);
    @(posedge clk); #1;
    chk2("w15", 1, 32'hA00F, 4'd15, 4'd0, 1'b1, 16'd2);
    @(posedge clk); #1;
    chk2("w0", 2, 32'hA000, 4'd0, 4'd1, 1'b1, 16'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk2("nohalt3", 5, 32'hFFFF_FFFF, 4'd3, 4'd4, 1'b1, 16'd6);
    @(posedge clk); #1;
    chk2("after3", 6, 32'hA004, 4'd4, 4'd5, 1'b1, 16'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
